// File: rtl/io_pkg.sv
// Register map and identity constants shared by the input-side peripherals.
// Address constants double as the read-mux select values.
package io_pkg;

  typedef enum logic [1:0] {
    IN_ADDR_LEVEL = 2'd0,
    IN_ADDR_RISE  = 2'd1,
    IN_ADDR_FALL  = 2'd2,
    IN_ADDR_ID    = 2'd3
  } in_addr_e;

  localparam logic [31:0] IN_ID_BASE     = 32'h001D_0000;
  localparam int unsigned IN_DIV_DEFAULT = 100000;

  // Block id word: fixed tag in the upper half, channel count in the low bits.
  function automatic logic [31:0] in_block_id(input int unsigned n_ch);
    return IN_ID_BASE | 32'(n_ch);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One-channel debouncer: adopts a new level after STABLE consecutive differing ticks.
// rise/fall are single-cycle combinational pulses aligned with the edge that updates level.
module debounce_ch #(
  parameter int unsigned STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (tick) begin
      if (sync_in == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        level_d = sync_in;
        cnt_d   = '0;
        rise    = sync_in;
        fall    = ~sync_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/input_reader.sv
// Switch/button reader: sync, debounce, sticky edge events, registered read-to-clear port.
// Read data/valid appear 1 clk after rd_en; no backpressure, rd_en may fire every cycle.
module input_reader
  import io_pkg::*;
#(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned DIV    = IN_DIV_DEFAULT,
  parameter int unsigned STABLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  input  logic            rd_en,
  input  logic [1:0]      rd_addr,
  output logic [31:0]     rd_data,
  output logic            rd_valid,
  output logic            irq
);

  localparam int unsigned TW = $clog2(DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            tick;

  logic [N_CH-1:0] level_w, rise_w, fall_w;
  logic [N_CH-1:0] rise_evt_q, rise_evt_d;
  logic [N_CH-1:0] fall_evt_q, fall_evt_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            irq_q, irq_d;
  logic [31:0]     rd_mux;
  logic            rd_rise, rd_fall;

  assign tick   = (tcnt_q == TCNT_LAST);
  assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_ch #(
      .STABLE (STABLE)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (sync2_q[i]),
      .level   (level_w[i]),
      .rise    (rise_w[i]),
      .fall    (fall_w[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      IN_ADDR_LEVEL: rd_mux[N_CH-1:0] = level_w;
      IN_ADDR_RISE:  rd_mux[N_CH-1:0] = rise_evt_q;
      IN_ADDR_FALL:  rd_mux[N_CH-1:0] = fall_evt_q;
      IN_ADDR_ID:    rd_mux           = in_block_id(N_CH);
      default:       rd_mux           = '0;
    endcase
  end

  assign rd_rise = rd_en && (rd_addr == IN_ADDR_RISE);
  assign rd_fall = rd_en && (rd_addr == IN_ADDR_FALL);

  // A read clears exactly what it returned; a pulse landing in the same cycle survives.
  always_comb begin
    rise_evt_d = rd_rise ? rise_w : (rise_evt_q | rise_w);
    fall_evt_d = rd_fall ? fall_w : (fall_evt_q | fall_w);
    rd_data_d  = rd_en ? rd_mux : rd_data_q;
    rd_valid_d = rd_en;
    irq_d      = (|rise_evt_q) | (|fall_evt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tcnt_q     <= '0;
      rise_evt_q <= '0;
      fall_evt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      tcnt_q     <= tcnt_d;
      rise_evt_q <= rise_evt_d;
      fall_evt_q <= fall_evt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule
